// File: rtl/uart_prog_loader_pkg.sv
// Shared types and constants for the UART program loader.
package uart_prog_loader_pkg;

  // Frame-level loader states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_DONE,
    ST_ERR
  } state_t;

  // Serial byte receiver states
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // Target memory select carried in upg_adr_o[14]
  localparam logic UPG_SEL_IMEM = 1'b0;
  localparam logic UPG_SEL_DMEM = 1'b1;

  localparam logic [31:0] ZERO_WORD = '0;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 serial byte receiver: 2-FF synchronizer, mid-bit sampling,
// false-start rejection and stop-bit framing check.
module uart_rx_byte
  import uart_prog_loader_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 10_000_000,
  parameter int unsigned BAUD     = 128_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_vld_o,
  output logic       frame_err_o
);

  localparam int unsigned BIT  = CLK_FREQ / BAUD;
  localparam int unsigned HALF = BIT / 2;
  localparam int unsigned CW   = $clog2(BIT + 1);

  logic          rx_m;
  logic          rx_s;
  logic          rx_d;
  rx_state_t     st;
  rx_state_t     st_nx;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          tick;

  // Synchronize the pin and keep one extra stage for falling-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx_i;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st <= RX_IDLE;
    else      st <= st_nx;
  end

  // Next-state logic: start-bit check at half a bit, then one sample per bit
  always_comb begin
    st_nx = st;
    unique case (st)
      RX_IDLE:  if (!rx_s && rx_d) st_nx = RX_START;
      RX_START: if (tick) st_nx = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick && bit_idx == 3'd7) st_nx = RX_STOP;
      RX_STOP:  if (tick) st_nx = RX_IDLE;
      default:  st_nx = RX_IDLE;
    endcase
  end

  // Sample strobe: half a bit into the start bit, full bit periods afterwards
  always_comb begin
    tick = 1'b0;
    unique case (st)
      RX_START:         tick = (cnt == CW'(HALF - 1));
      RX_DATA, RX_STOP: tick = (cnt == CW'(BIT - 1));
      default:          tick = 1'b0;
    endcase
  end

  // Bit timer, data shifter and registered byte outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      byte_o      <= '0;
      byte_vld_o  <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      byte_vld_o  <= 1'b0;
      frame_err_o <= 1'b0;
      if (st == RX_IDLE || tick) cnt <= '0;
      else                       cnt <= cnt + 1'b1;
      if (st == RX_START) bit_idx <= '0;
      if (st == RX_DATA && tick) begin
        shreg   <= {rx_s, shreg[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end
      if (st == RX_STOP && tick) begin
        byte_o      <= shreg;
        byte_vld_o  <= 1'b1;
        frame_err_o <= !rx_s;
      end
    end
  end

endmodule

// File: rtl/uart_prog_loader.sv
// UART programming-port writer: parses CMD/LEN/DATA frames and emits
// little-endian 32-bit word writes to instruction ROM or data RAM.
module uart_prog_loader
  import uart_prog_loader_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 10_000_000,
  parameter int unsigned BAUD      = 128_000,
  parameter int unsigned MAX_WORDS = 16384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        rx_i,
  output logic        upg_rst_o,
  output logic        upg_wen_o,
  output logic [14:0] upg_adr_o,
  output logic [31:0] upg_dat_o,
  output logic        upg_done_o,
  output logic        err_o
);

  logic [7:0]  rx_byte;
  logic        byte_vld;
  logic        frame_err;
  logic        byte_ok;
  logic        byte_bad;

  state_t      state;
  state_t      state_nx;
  logic        sel;
  logic [7:0]  len_lo;
  logic [14:0] len;
  logic [15:0] len_full;
  logic [23:0] word;
  logic [1:0]  lane;
  logic [14:0] wr_cnt;

  uart_rx_byte #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx_i       (rx_i),
    .byte_o     (rx_byte),
    .byte_vld_o (byte_vld),
    .frame_err_o(frame_err)
  );

  assign byte_ok  = byte_vld && !frame_err;
  assign byte_bad = byte_vld && frame_err;
  assign len_full = {rx_byte, len_lo};

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  // Next-state logic for the frame parser
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE, ST_DONE, ST_ERR: if (start_i) state_nx = ST_CMD;
      ST_CMD: begin
        if (byte_bad) state_nx = ST_ERR;
        else if (byte_ok) state_nx = (rx_byte[7:1] != '0) ? ST_ERR : ST_LEN0;
      end
      ST_LEN0: begin
        if (byte_bad)     state_nx = ST_ERR;
        else if (byte_ok) state_nx = ST_LEN1;
      end
      ST_LEN1: begin
        if (byte_bad) state_nx = ST_ERR;
        else if (byte_ok) begin
          if (len_full == '0)                 state_nx = ST_DONE;
          else if (len_full > 16'(MAX_WORDS)) state_nx = ST_ERR;
          else                                state_nx = ST_DATA;
        end
      end
      // wr_cnt is bumped on the same edge that raises the strobe, so the
      // final-write test sees the post-increment count.
      ST_DATA: begin
        if (byte_bad)                          state_nx = ST_ERR;
        else if (upg_wen_o && wr_cnt == len)   state_nx = ST_DONE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the state
  always_comb begin
    upg_rst_o  = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR);
    upg_done_o = (state == ST_DONE);
    err_o      = (state == ST_ERR);
  end

  // Header capture, word assembly and write strobe generation
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel       <= UPG_SEL_IMEM;
      len_lo    <= '0;
      len       <= '0;
      word      <= '0;
      lane      <= '0;
      wr_cnt    <= '0;
      upg_wen_o <= 1'b0;
      upg_adr_o <= '0;
      upg_dat_o <= ZERO_WORD;
    end else begin
      upg_wen_o <= 1'b0;
      unique case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start_i) begin
            wr_cnt <= '0;
            lane   <= '0;
            sel    <= UPG_SEL_IMEM;
          end
        end
        ST_CMD:  if (byte_ok) sel    <= rx_byte[0];
        ST_LEN0: if (byte_ok) len_lo <= rx_byte;
        ST_LEN1: if (byte_ok) len    <= len_full[14:0];
        ST_DATA: begin
          if (byte_ok) begin
            lane <= lane + 1'b1;
            unique case (lane)
              2'd0: word[7:0]   <= rx_byte;
              2'd1: word[15:8]  <= rx_byte;
              2'd2: word[23:16] <= rx_byte;
              default: begin
                upg_wen_o <= 1'b1;
                upg_dat_o <= {rx_byte, word};
                upg_adr_o <= {sel, wr_cnt[13:0]};
                wr_cnt    <= wr_cnt + 1'b1;
              end
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench for uart_prog_loader: a frame-level model predicts
// every write and the final status; a compare process checks each cycle.
module tb_uart_prog_loader;

  localparam int BIT = 10_000_000 / 128_000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic        rx_i = 1'b1;
  logic        upg_rst_o;
  logic        upg_wen_o;
  logic [14:0] upg_adr_o;
  logic [31:0] upg_dat_o;
  logic        upg_done_o;
  logic        err_o;

  int n_chk = 0;
  int n_fail = 0;

  logic [46:0] exp_q[$];
  logic [14:0] exp_adr = '0;
  logic [31:0] exp_dat = '0;
  logic [7:0]  fb[$];
  int          bad_idx = -1;
  int          oc;

  logic [14:0] wr_adr_log[16];
  logic [31:0] wr_dat_log[16];
  int          n_wr = 0;
  int          vld_cnt = 0;

  uart_prog_loader #(
    .CLK_FREQ (10_000_000),
    .BAUD     (128_000),
    .MAX_WORDS(16384)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .rx_i      (rx_i),
    .upg_rst_o (upg_rst_o),
    .upg_wen_o (upg_wen_o),
    .upg_adr_o (upg_adr_o),
    .upg_dat_o (upg_dat_o),
    .upg_done_o(upg_done_o),
    .err_o     (err_o)
  );

  always #50 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Per-cycle comparison against the model's expected write stream
  always @(negedge clk) begin
    logic [46:0] e;
    if (!rst) begin
      exp_q.delete();
      exp_adr = '0;
      exp_dat = '0;
      chk("rst_wen", 32'(upg_wen_o), 0);
      chk("rst_upg_rst", 32'(upg_rst_o), 1);
      chk("rst_done", 32'(upg_done_o), 0);
      chk("rst_err", 32'(err_o), 0);
      chk("rst_adr", 32'(upg_adr_o), 0);
      chk("rst_dat", upg_dat_o, 0);
    end else begin
      if (upg_wen_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_wen", 1, 0);
        end else begin
          e = exp_q.pop_front();
          exp_adr = e[46:32];
          exp_dat = e[31:0];
        end
        if (n_wr < 16) begin
          wr_adr_log[n_wr] = upg_adr_o;
          wr_dat_log[n_wr] = upg_dat_o;
        end
        n_wr++;
      end
      chk("adr", 32'(upg_adr_o), 32'(exp_adr));
      chk("dat", upg_dat_o, exp_dat);
    end
  end

  always @(negedge clk) if (dut.u_rx.byte_vld_o) vld_cnt++;

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame model: outcome 0 = still busy, 1 = done, 2 = error
  task automatic model_frame(output int outcome);
    logic [7:0]  c;
    int          n;
    logic [31:0] w;
    int          idx;
    outcome = 0;
    if (fb.size() < 1) return;
    if (bad_idx == 0) begin outcome = 2; return; end
    c = fb[0];
    if (c[7:1] != 7'd0) begin outcome = 2; return; end
    if (fb.size() < 3) return;
    if (bad_idx == 1 || bad_idx == 2) begin outcome = 2; return; end
    n = int'(fb[1]) + 256 * int'(fb[2]);
    if (n == 0) begin outcome = 1; return; end
    if (n > 16384) begin outcome = 2; return; end
    for (int wi = 0; wi < n; wi++) begin
      w = '0;
      for (int k = 0; k < 4; k++) begin
        idx = 3 + 4 * wi + k;
        if (idx >= fb.size()) return;
        if (idx == bad_idx) begin outcome = 2; return; end
        w = w | (32'(fb[idx]) << (8 * k));
      end
      exp_q.push_back({c[0], 14'(wi), w});
    end
    outcome = 1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx_i = 1'b0;
    hold(BIT);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      hold(BIT);
    end
    rx_i = stop;
    hold(BIT);
    rx_i = 1'b1;
    hold(4);
  endtask

  task automatic do_start();
    start_i = 1'b1;
    hold(1);
    start_i = 1'b0;
    chk("start_upg_rst", 32'(upg_rst_o), 0);
    chk("start_done", 32'(upg_done_o), 0);
    chk("start_err", 32'(err_o), 0);
  endtask

  task automatic run_frame();
    n_wr = 0;
    model_frame(oc);
    for (int i = 0; i < fb.size(); i++) send_byte(fb[i], (i != bad_idx));
    hold(20);
    chk("end_done", 32'(upg_done_o), 32'(oc == 1));
    chk("end_err", 32'(err_o), 32'(oc == 2));
    chk("end_upg_rst", 32'(upg_rst_o), 32'(oc != 0));
    chk("pending_writes", 32'(exp_q.size()), 0);
  endtask

  initial begin
    hold(3);
    chk("t1_upg_rst", 32'(upg_rst_o), 1);
    chk("t1_done", 32'(upg_done_o), 0);
    rst = 1'b1;
    hold(5);

    // Two words to instruction ROM
    do_start();
    fb = '{8'h00, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    bad_idx = -1;
    run_frame();
    chk("t2_nwr", n_wr, 2);
    chk("t2_adr0", 32'(wr_adr_log[0]), 32'h0000);
    chk("t2_dat0", wr_dat_log[0], 32'h12345678);
    chk("t2_adr1", 32'(wr_adr_log[1]), 32'h0001);
    chk("t2_dat1", wr_dat_log[1], 32'hDEADBEEF);
    chk("t2_done", 32'(upg_done_o), 1);

    // One word to data RAM
    do_start();
    fb = '{8'h01, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
    run_frame();
    chk("t3_nwr", n_wr, 1);
    chk("t3_adr", 32'(wr_adr_log[0]), 32'h4000);
    chk("t3_dat", wr_dat_log[0], 32'h00000001);

    // Zero length, then oversize length
    do_start();
    fb = '{8'h00, 8'h00, 8'h00};
    run_frame();
    chk("t4_zero_nwr", n_wr, 0);
    chk("t4_zero_done", 32'(upg_done_o), 1);
    do_start();
    fb = '{8'h00, 8'h01, 8'h40};
    run_frame();
    chk("t4_big_nwr", n_wr, 0);
    chk("t4_big_err", 32'(err_o), 1);

    // Framing error after one word, then reserved CMD bits
    do_start();
    fb = '{8'h00, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    bad_idx = 7;
    run_frame();
    chk("t5_nwr", n_wr, 1);
    chk("t5_adr", 32'(wr_adr_log[0]), 32'h0000);
    chk("t5_dat", wr_dat_log[0], 32'h44332211);
    chk("t5_err", 32'(err_o), 1);
    chk("t5_done", 32'(upg_done_o), 0);
    bad_idx = -1;
    do_start();
    fb = '{8'h80};
    run_frame();
    chk("t5_cmd_err", 32'(err_o), 1);

    // Reset in the middle of the data bytes
    do_start();
    fb = '{8'h00, 8'h02, 8'h00, 8'h78, 8'h56};
    n_wr = 0;
    model_frame(oc);
    for (int i = 0; i < fb.size(); i++) send_byte(fb[i], 1'b1);
    rx_i = 1'b0;
    hold(30);
    rst = 1'b0;
    hold(3);
    rx_i = 1'b1;
    rst = 1'b1;
    hold(200);
    chk("t6_nwr", n_wr, 0);
    chk("t6_upg_rst", 32'(upg_rst_o), 1);
    chk("t6_err", 32'(err_o), 0);
    do_start();
    fb = '{8'h00, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_frame();
    chk("t6_reload_nwr", n_wr, 2);
    chk("t6_reload_dat1", wr_dat_log[1], 32'hDEADBEEF);

    // Short low glitch must not create a byte
    do_start();
    vld_cnt = 0;
    rx_i = 1'b0;
    hold(BIT / 4);
    rx_i = 1'b1;
    hold(200);
    chk("t6_glitch_vld", vld_cnt, 0);
    fb = '{8'h01, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_frame();
    chk("t6_glitch_dat", wr_dat_log[0], 32'hDDCCBBAA);
    chk("t6_glitch_adr", 32'(wr_adr_log[0]), 32'h4000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
